// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Bus-cycle engine for the RTC chip's multiplexed address/data bus. It takes
// one register access (address, read/write, write data) and runs an address
// phase, an idle gap and a data phase, each with setup/pulse/hold timing.
// Read data is captured at the end of the read strobe and returned with a
// one-cycle done pulse.
//
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-low reset
//   start           request pulse, sampled only while idle
//   op_wr           1 = write, 0 = read (captured with start)
//   addr, wdata     register address / write data (captured with start)
//   ad_in           bus value from the pad (read path)
//   ad_out, ad_oe   bus value to the pad and its output enable
//   cs_n, ad_n      chip select (low active), 0 = address phase
//   wr_n, rd_n      write / read strobes, low active
//   rdata           last captured read data
//   busy, done      access in flight / one-cycle completion pulse
module rtc_bus_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam int T_M1  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_M2  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            op_q, nxt_op;
  logic [7:0]      addr_q, wdata_q, nxt_addr, nxt_wdata;
  logic            a_ph, d_ph;

  // Counter holds the remaining cycles of the current state minus one.
  function automatic logic [CW-1:0] dur(state_t s);
    case (s)
      A_SETUP, D_SETUP: dur = CW'(T_SETUP - 1);
      A_PULSE, D_PULSE: dur = CW'(T_PULSE - 1);
      A_HOLD,  D_HOLD:  dur = CW'(T_HOLD - 1);
      GAP:              dur = CW'(T_GAP - 1);
      default:          dur = '0;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = A_SETUP;
      A_SETUP: if (cnt == '0) nxt = A_PULSE;
      A_PULSE: if (cnt == '0) nxt = A_HOLD;
      A_HOLD:  if (cnt == '0) nxt = GAP;
      GAP:     if (cnt == '0) nxt = D_SETUP;
      D_SETUP: if (cnt == '0) nxt = D_PULSE;
      D_PULSE: if (cnt == '0) nxt = D_HOLD;
      D_HOLD:  if (cnt == '0) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    nxt_cnt = cnt;
    if (nxt != state)    nxt_cnt = dur(nxt);
    else if (cnt != '0)  nxt_cnt = cnt - 1'b1;
  end

  // Request fields are only ever loaded from IDLE, so they stay stable for the
  // whole access and a start while busy has no effect.
  always_comb begin
    nxt_op    = op_q;
    nxt_addr  = addr_q;
    nxt_wdata = wdata_q;
    if (state == IDLE && start) begin
      nxt_op    = op_wr;
      nxt_addr  = addr;
      nxt_wdata = wdata;
    end
  end

  // Outputs are decoded from the next state and registered, so the pins are
  // glitch-free and line up exactly with the state they belong to.
  assign a_ph = (nxt == A_SETUP) || (nxt == A_PULSE) || (nxt == A_HOLD);
  assign d_ph = (nxt == D_SETUP) || (nxt == D_PULSE) || (nxt == D_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= nxt_cnt;
      op_q    <= nxt_op;
      addr_q  <= nxt_addr;
      wdata_q <= nxt_wdata;
      cs_n    <= !(a_ph || d_ph);
      ad_n    <= !a_ph;
      // The address is always latched by the chip with WR, even for reads.
      wr_n    <= !((nxt == A_PULSE) || (nxt == D_PULSE && nxt_op));
      rd_n    <= !(nxt == D_PULSE && !nxt_op);
      ad_oe   <= a_ph || (d_ph && nxt_op);
      ad_out  <= a_ph ? nxt_addr : ((d_ph && nxt_op) ? nxt_wdata : 8'h00);
      busy    <= (nxt != IDLE);
      done    <= (nxt == DONE);
      // Sample the bus on the edge that closes the read strobe.
      if (state == D_PULSE && cnt == '0 && !op_q) rdata <= ad_in;
    end
  end

endmodule
